lfsr_bit_stats: RTL

Parametrised windowed bit-statistics engine for the LFSR test path. It counts ones, zeros, bit transitions and (optionally) the longest run over a programmable window of shift-enabled samples. At the end of each window it publishes a registered snapshot with a one-cycle done pulse. It sits downstream of the LFSR serial output and drives the seven-segment/UART readout logic.

---
 rtl/lfsr_pkg.sv | 21 ++
 rtl/lfsr_bit_stats_sat_counter.sv | 23 ++
 rtl/lfsr_bit_stats.sv | 130 +++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared types for the LFSR bit-statistics path: FSM state encoding and counter sizing.
// Pure declarations; no logic, latency or backpressure of its own.
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Bits needed to hold values 0..n-1 (ceil(log2(n))).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lfsr_bit_stats_sat_counter.sv
// Saturating up-counter; clr loads inc (0 or 1) so a count can restart at 1 in one cycle.
// Latency: one cycle; no backpressure, holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= W'(inc);
    end else if (inc && !(&q)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/lfsr_bit_stats.sv
// Windowed ones/zeros/transition/longest-run statistics; run tracking only with LFSR_BIT_STATS_RUN_EN.
// Latency: snapshot and done one cycle after the final sample edge; no backpressure, cont selects restart or hold.
module lfsr_bit_stats
  import lfsr_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int WINDOW = 256,
  parameter int RUN_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cont,
  input  logic             sh_en,
  input  logic             i0,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ones,
  output logic [CNT_W-1:0] zeros,
  output logic [CNT_W-1:0] transitions,
  output logic [RUN_W-1:0] max_run
);

  localparam int SCNT_W = clog2(WINDOW + 1);

  state_t            state, state_nx;
  logic [SCNT_W-1:0] scnt;
  logic              first;
  logic              prev_bit;

  logic              in_count, smp, win_end, start_acc, clr_live, diff;
  logic [CNT_W-1:0]  ones_q, zeros_q, trans_q;
  logic [CNT_W-1:0]  ones_nx, zeros_nx, trans_nx;
  logic [RUN_W-1:0]  max_nx;

  assign in_count  = (state == ST_COUNT);
  assign smp       = in_count && sh_en;
  assign win_end   = smp && (scnt == SCNT_W'(WINDOW - 1));
  assign start_acc = start && !in_count;
  assign clr_live  = start_acc || win_end;
  assign diff      = !first && (i0 != prev_bit);

  // Live counters restart at window end; the final sample reaches the snapshot via *_nx.
  sat_counter #(.W(CNT_W)) u_ones (
    .clk(clk), .reset(reset), .clr(clr_live), .inc(smp && i0 && !win_end), .q(ones_q)
  );
  sat_counter #(.W(CNT_W)) u_zeros (
    .clk(clk), .reset(reset), .clr(clr_live), .inc(smp && !i0 && !win_end), .q(zeros_q)
  );
  sat_counter #(.W(CNT_W)) u_trans (
    .clk(clk), .reset(reset), .clr(clr_live), .inc(smp && diff && !win_end), .q(trans_q)
  );

  assign ones_nx  = (i0 && !(&ones_q))    ? ones_q + CNT_W'(1)  : ones_q;
  assign zeros_nx = (!i0 && !(&zeros_q))  ? zeros_q + CNT_W'(1) : zeros_q;
  assign trans_nx = (diff && !(&trans_q)) ? trans_q + CNT_W'(1) : trans_q;

`ifdef LFSR_BIT_STATS_RUN_EN
  logic [RUN_W-1:0] run_q, run_nx, live_max;

  // A new run starts (clr with inc -> 1) on the first sample or on a bit change.
  sat_counter #(.W(RUN_W)) u_run (
    .clk(clk), .reset(reset),
    .clr(clr_live || (smp && (first || diff))),
    .inc(smp && !win_end),
    .q(run_q)
  );

  assign run_nx = (first || diff) ? RUN_W'(1) :
                  (&run_q)        ? run_q     : run_q + RUN_W'(1);
  assign max_nx = (run_nx > live_max) ? run_nx : live_max;

  always_ff @(posedge clk) begin
    if (reset || clr_live) begin
      live_max <= '0;
    end else if (smp) begin
      live_max <= max_nx;
    end
  end
`else
  assign max_nx = '0;
`endif

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    unique case (state)
      ST_IDLE, ST_HOLD: begin
        if (start) state_nx = ST_COUNT;
      end
      ST_COUNT: begin
        busy = 1'b1;
        if (win_end && !cont) state_nx = ST_HOLD;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      scnt        <= '0;
      first       <= 1'b0;
      prev_bit    <= 1'b0;
      done        <= 1'b0;
      ones        <= '0;
      zeros       <= '0;
      transitions <= '0;
      max_run     <= '0;
    end else begin
      state <= state_nx;
      done  <= win_end;
      if (clr_live) begin
        scnt  <= '0;
        first <= 1'b1;
      end else if (smp) begin
        scnt  <= scnt + SCNT_W'(1);
        first <= 1'b0;
      end
      if (smp) prev_bit <= i0;
      if (win_end) begin
        ones        <= ones_nx;
        zeros       <= zeros_nx;
        transitions <= trans_nx;
        max_run     <= max_nx;
      end
    end
  end

endmodule
